// File: rtl/e_muldiv_unit.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// Runs multi-cycle mult/div and applies mthi/mtlo writes while idle.
module e_muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hiloop,
    input  logic        start,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [10:0] HILO_MULT  = 11'd1;
    localparam logic [10:0] HILO_MULTU = 11'd2;
    localparam logic [10:0] HILO_DIV   = 11'd3;
    localparam logic [10:0] HILO_DIVU  = 11'd4;
    localparam logic [10:0] HILO_TOHI  = 11'd5;
    localparam logic [10:0] HILO_TOLO  = 11'd6;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [31:0]        hi_tmp, lo_tmp, hi_tmp_nxt, lo_tmp_nxt;
    logic [31:0]        hi_nxt, lo_nxt;

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        a_mag, b_mag, q_mag, r_mag;
    logic [31:0]        q_s, r_s, q_u, r_u;
    logic               div_zero;

    // Arithmetic datapath; signed divide done on magnitudes so MIN/-1 wraps cleanly
    always_comb begin
        prod_s   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
        div_zero = (rt_data == 32'd0);
        a_mag    = rs_data[31] ? (~rs_data + 32'd1) : rs_data;
        b_mag    = rt_data[31] ? (~rt_data + 32'd1) : rt_data;
        q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
        q_s      = (rs_data[31] ^ rt_data[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s      = rs_data[31] ? (~r_mag + 32'd1) : r_mag;
        q_u      = div_zero ? 32'd0 : (rs_data / rt_data);
        r_u      = div_zero ? 32'd0 : (rs_data % rt_data);
    end

    // Next-state and register updates
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        hi_tmp_nxt = hi_tmp;
        lo_tmp_nxt = lo_tmp;
        hi_nxt     = hi;
        lo_nxt     = lo;

        case (state)
            S_IDLE: begin
                if (start) begin
                    case (hiloop)
                        HILO_MULT: begin
                            {hi_tmp_nxt, lo_tmp_nxt} = prod_s;
                            cnt_nxt   = CNT_W'(MULT_CYCLES);
                            state_nxt = S_RUN;
                        end
                        HILO_MULTU: begin
                            {hi_tmp_nxt, lo_tmp_nxt} = prod_u;
                            cnt_nxt   = CNT_W'(MULT_CYCLES);
                            state_nxt = S_RUN;
                        end
                        HILO_DIV: begin
                            hi_tmp_nxt = div_zero ? hi : r_s;
                            lo_tmp_nxt = div_zero ? lo : q_s;
                            cnt_nxt    = CNT_W'(DIV_CYCLES);
                            state_nxt  = S_RUN;
                        end
                        HILO_DIVU: begin
                            hi_tmp_nxt = div_zero ? hi : r_u;
                            lo_tmp_nxt = div_zero ? lo : q_u;
                            cnt_nxt    = CNT_W'(DIV_CYCLES);
                            state_nxt  = S_RUN;
                        end
                        default: ;
                    endcase
                end else if (hiloop == HILO_TOHI) begin
                    hi_nxt = rs_data;
                end else if (hiloop == HILO_TOLO) begin
                    lo_nxt = rs_data;
                end
            end
            S_RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_nxt    = hi_tmp;
                    lo_nxt    = lo_tmp;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi_tmp <= '0;
            lo_tmp <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            busy   <= (cnt_nxt != '0);
            hi_tmp <= hi_tmp_nxt;
            lo_tmp <= lo_tmp_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed self-checking bench for e_muldiv_unit with hand-computed HI/LO results.
module tb_e_muldiv_unit;

    logic        clk;
    logic        reset;
    logic [10:0] hiloop;
    logic        start;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .hiloop  (hiloop),
        .start   (start),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single rising edge, then return to idle inputs
    task automatic issue(input logic [10:0] code, input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        hiloop  = code;
        start   = s;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        hiloop  = 11'd0;
        start   = 1'b0;
    endtask

    // busy must stay high for exactly n cycles, then results appear as busy falls
    task automatic expect_run(input string tag, input int n, input logic [31:0] eh, input logic [31:0] el);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        end
        @(negedge clk);
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_hi"}, hi, eh);
        check({tag, "_lo"}, lo, el);
    endtask

    initial begin
        hiloop  = 11'd0;
        start   = 1'b0;
        rs_data = 32'd0;
        rt_data = 32'd0;
        reset   = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(11'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        expect_run("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        issue(11'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
        expect_run("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

        issue(11'd3, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        expect_run("div_neg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(11'd4, 1'b1, 32'd7, 32'd2);
        expect_run("divu", 10, 32'd1, 32'd3);

        issue(11'd3, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_run("div_ovf", 10, 32'd0, 32'h8000_0000);

        issue(11'd5, 1'b0, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", hi, 32'hDEAD_BEEF);
        check("mthi_lo", lo, 32'h8000_0000);
        issue(11'd6, 1'b0, 32'hCAFE_BABE, 32'd0);
        check("mtlo_lo", lo, 32'hCAFE_BABE);
        check("mtlo_hi", hi, 32'hDEAD_BEEF);

        issue(11'd5, 1'b1, 32'h0000_0001, 32'd0);
        check("mthi_start_hi", hi, 32'hDEAD_BEEF);
        check("mthi_start_busy", 32'(busy), 32'd0);

        issue(11'd5, 1'b0, 32'h0000_1234, 32'd0);
        issue(11'd6, 1'b0, 32'h0000_5678, 32'd0);
        issue(11'd3, 1'b1, 32'd5, 32'd0);
        expect_run("div0", 10, 32'h0000_1234, 32'h0000_5678);

        issue(11'd1, 1'b1, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ign_busy_hi", 32'(busy), 32'd1);
            if (i == 0) begin
                hiloop = 11'd3; start = 1'b1; rs_data = 32'd9; rt_data = 32'd3;
            end else if (i == 1) begin
                hiloop = 11'd5; start = 1'b0; rs_data = 32'h0000_FFFF;
            end else begin
                hiloop = 11'd0; start = 1'b0;
            end
        end
        @(negedge clk);
        check("ign_busy_lo", 32'(busy), 32'd0);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd12);
        repeat (12) @(negedge clk);
        check("ign_no_late_busy", 32'(busy), 32'd0);
        check("ign_no_late_lo", lo, 32'd12);

        issue(11'd4, 1'b1, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (14) @(negedge clk);
        check("arst_late_busy", 32'(busy), 32'd0);
        check("arst_late_hi", hi, 32'd0);
        check("arst_late_lo", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
